// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter
// Shares one sram-like memory port (toward the AXI bridge) between the
// instruction-cache miss path (i_*) and the data-cache miss/uncached path (d_*).
// Only one transaction is outstanding at a time. The grant is held from the
// request until data_ok. The owner's bundle is passed combinationally to m_*.
//
// Optional feature macro: ARB_RR_EN
//   defined   : round-robin tie break using a 1-bit last-grant register
//   undefined : fixed priority, data side wins ties
//
// Ports:
//   clk, rst                    clock; synchronous active-low reset
//   i_req/i_wr/i_size/i_addr/i_wdata   inst-side request bundle (in)
//   i_rdata/i_addr_ok/i_data_ok        inst-side response (out)
//   d_req/d_wr/d_size/d_addr/d_wdata   data-side request bundle (in)
//   d_rdata/d_addr_ok/d_data_ok        data-side response (out)
//   m_req/m_wr/m_size/m_addr/m_wdata   bus-side request bundle (out)
//   m_rdata/m_addr_ok/m_data_ok        bus-side response (in)
module cache_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic                  i_wr,
  input  logic [1:0]            i_size,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_addr_ok,
  output logic                  i_data_ok,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [1:0]            d_size,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_addr_ok,
  output logic                  d_data_ok,
  output logic                  m_req,
  output logic                  m_wr,
  output logic [1:0]            m_size,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_addr_ok,
  input  logic                  m_data_ok
);

  typedef enum logic [2:0] {
    StIdle,
    StReqI,
    StReqD,
    StRspI,
    StRspD
  } state_e;

  state_e state_q, state_d;

  logic gnt_data;  // IDLE winner: 1 = data side
  logic use_data;  // bundle currently routed to m_*
  logic req_sel;   // request forwarded to m_req before reset gating

`ifdef ARB_RR_EN
  logic last_gnt_q, last_gnt_d;  // 1 = data side was granted last

  // On a tie the side that was not granted last wins.
  always_comb begin
    gnt_data = d_req && (!i_req || !last_gnt_q);
  end
`else
  always_comb begin
    gnt_data = d_req;
  end
`endif

  always_comb begin
    state_d  = state_q;
    use_data = 1'b0;
    req_sel  = 1'b0;

    unique case (state_q)
      StIdle: begin
        use_data = gnt_data;
        req_sel  = gnt_data ? d_req : i_req;
        if (req_sel && m_addr_ok) begin
          state_d = gnt_data ? StRspD : StRspI;
        end else if (req_sel) begin
          state_d = gnt_data ? StReqD : StReqI;
        end
      end
      StReqI: begin
        req_sel = i_req;
        // An owner dropping req before addr_ok releases the grant.
        if (!i_req) begin
          state_d = StIdle;
        end else if (m_addr_ok) begin
          state_d = StRspI;
        end
      end
      StReqD: begin
        use_data = 1'b1;
        req_sel  = d_req;
        if (!d_req) begin
          state_d = StIdle;
        end else if (m_addr_ok) begin
          state_d = StRspD;
        end
      end
      StRspI: begin
        if (m_data_ok) begin
          state_d = StIdle;
        end
      end
      StRspD: begin
        use_data = 1'b1;
        if (m_data_ok) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    m_wr      = use_data ? d_wr    : i_wr;
    m_size    = use_data ? d_size  : i_size;
    m_addr    = use_data ? d_addr  : i_addr;
    m_wdata   = use_data ? d_wdata : i_wdata;
    m_req     = req_sel;
    i_addr_ok = req_sel && m_addr_ok && !use_data;
    d_addr_ok = req_sel && m_addr_ok && use_data;
    // m_data_ok outside a response state is stale and dropped.
    i_data_ok = (state_q == StRspI) && m_data_ok;
    d_data_ok = (state_q == StRspD) && m_data_ok;

    if (!rst) begin
      m_req     = 1'b0;
      i_addr_ok = 1'b0;
      d_addr_ok = 1'b0;
      i_data_ok = 1'b0;
      d_data_ok = 1'b0;
    end
  end

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

`ifdef ARB_RR_EN
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (m_req && m_addr_ok) begin
      last_gnt_d = use_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
`ifdef ARB_RR_EN
      last_gnt_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
`ifdef ARB_RR_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (who owns the bus, whether its address was taken).
module tb_cache_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_addr_ok, m_data_ok;

  always #5 clk = ~clk;

  cache_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: owner 0 = nobody, 1 = inst, 2 = data; accepted = address taken.
  int owner;
  bit accepted;
  bit last_data;
  int e_win;
  bit e_mreq, e_iaok, e_daok, e_idok, e_ddok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    if (i_req && d_req) begin
`ifdef ARB_RR_EN
      return last_data ? 1 : 2;
`else
      return 2;
`endif
    end
    return d_req ? 2 : 1;
  endfunction

  // Expected outputs for the current cycle, compared against the DUT.
  task automatic sample();
    @(negedge clk);
    if (!rst) begin
      e_win = 0;
      e_mreq = 0;
    end else if (owner == 0) begin
      e_win = pick();
      e_mreq = (e_win == 2) ? d_req : i_req;
    end else begin
      e_win = owner;
      e_mreq = accepted ? 1'b0 : ((owner == 2) ? d_req : i_req);
    end
    e_iaok = e_mreq && m_addr_ok && (e_win == 1);
    e_daok = e_mreq && m_addr_ok && (e_win == 2);
    e_idok = rst && (owner == 1) && accepted && m_data_ok;
    e_ddok = rst && (owner == 2) && accepted && m_data_ok;
    chk("m_req", m_req, e_mreq);
    chk("i_addr_ok", i_addr_ok, e_iaok);
    chk("d_addr_ok", d_addr_ok, e_daok);
    chk("i_data_ok", i_data_ok, e_idok);
    chk("d_data_ok", d_data_ok, e_ddok);
    if (e_mreq) begin
      chk("m_addr", m_addr, (e_win == 2) ? d_addr : i_addr);
      chk("m_wr", m_wr, (e_win == 2) ? d_wr : i_wr);
      chk("m_size", m_size, (e_win == 2) ? d_size : i_size);
      chk("m_wdata", m_wdata, (e_win == 2) ? d_wdata : i_wdata);
    end
    if (rst) begin
      chk("i_rdata", i_rdata, m_rdata);
      chk("d_rdata", d_rdata, m_rdata);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst) begin
      owner = 0;
      accepted = 0;
      last_data = 1;
    end else if (e_mreq && m_addr_ok) begin
      owner = e_win;
      accepted = 1;
      last_data = (e_win == 2);
    end else if (owner == 0 && e_mreq) begin
      owner = e_win;
      accepted = 0;
    end else if (owner != 0 && !accepted && !e_mreq) begin
      owner = 0;
    end else if (accepted && m_data_ok) begin
      owner = 0;
      accepted = 0;
    end
    #1;
  endtask

  int obs[8];
  int n_obs;
  int exp_gnt[8];
  bit i_got, d_got, pend_i, pend_d;

  initial begin
    owner = 0; accepted = 0; last_data = 1;
    rst = 0;
    i_req = 0; i_wr = 0; i_size = 2; i_addr = 0; i_wdata = 0;
    d_req = 0; d_wr = 0; d_size = 2; d_addr = 0; d_wdata = 0;
    m_rdata = 0; m_addr_ok = 0; m_data_ok = 0;
    #1;

    // Reset forces handshakes low even with everything asserted.
    i_req = 1; d_req = 1; m_addr_ok = 1; m_data_ok = 1;
    sample();
    chk("rst_m_req", m_req, 0);
    chk("rst_d_addr_ok", d_addr_ok, 0);
    advance();
    sample(); advance();
    rst = 1; i_req = 0; d_req = 0; m_addr_ok = 0; m_data_ok = 0;

    // Inst-only read.
    i_req = 1; i_addr = 32'hBFC0_0000; i_wr = 0; m_addr_ok = 1;
    sample();
    chk("ird_addr_ok", i_addr_ok, 1);
    chk("ird_m_addr", m_addr, 32'hBFC0_0000);
    chk("ird_d_addr_ok", d_addr_ok, 0);
    advance();
    i_req = 0; m_addr_ok = 0;
    sample(); chk("ird_wait", i_data_ok, 0); advance();
    m_data_ok = 1; m_rdata = 32'h3C1D_BFC0;
    sample();
    chk("ird_data_ok", i_data_ok, 1);
    chk("ird_rdata", i_rdata, 32'h3C1D_BFC0);
    chk("ird_d_data_ok", d_data_ok, 0);
    advance();
    m_data_ok = 0;

    // Simultaneous requests; inst was granted last so data wins in both builds.
    i_req = 1; i_addr = 32'h1FC0_0100;
    d_req = 1; d_wr = 1; d_addr = 32'h8000_1000; d_wdata = 32'hDEAD_BEEF; m_addr_ok = 1;
    sample();
    chk("sim_m_addr", m_addr, 32'h8000_1000);
    chk("sim_m_wr", m_wr, 1);
    chk("sim_m_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("sim_d_addr_ok", d_addr_ok, 1);
    advance();
    d_req = 0; d_wr = 0;
    sample(); chk("outst_m_req", m_req, 0); chk("outst_i_aok", i_addr_ok, 0); advance();
    m_data_ok = 1; m_addr_ok = 0;
    sample(); chk("sim_d_data_ok", d_data_ok, 1); chk("bubble_m_req", m_req, 0); advance();
    m_data_ok = 0;
    sample(); chk("next_m_req", m_req, 1); chk("next_m_addr", m_addr, 32'h1FC0_0100); advance();

    // Locked grant: data request rises while inst waits for addr_ok.
    d_req = 1; d_addr = 32'h8000_2000;
    for (int k = 0; k < 2; k++) begin
      sample(); chk("lock_m_addr", m_addr, 32'h1FC0_0100); chk("lock_d_aok", d_addr_ok, 0);
      advance();
    end
    m_addr_ok = 1;
    sample(); chk("lock_i_aok", i_addr_ok, 1); chk("lock_d_aok2", d_addr_ok, 0); advance();
    i_req = 0;
    sample(); chk("rspi_m_req", m_req, 0); chk("rspi_d_aok", d_addr_ok, 0); advance();
    m_data_ok = 1;
    sample(); chk("rspi_i_dok", i_data_ok, 1); advance();
    m_data_ok = 0;
    sample(); chk("dgrant_aok", d_addr_ok, 1); chk("dgrant_addr", m_addr, 32'h8000_2000);
    advance();

    // Reset during the data response; the stale data_ok must be dropped.
    d_req = 0; m_addr_ok = 0; rst = 0;
    sample(); advance();
    rst = 1; m_data_ok = 1;
    sample(); chk("stale_d_dok", d_data_ok, 0); chk("stale_i_dok", i_data_ok, 0); advance();
    m_data_ok = 0; d_req = 1; d_addr = 32'h8000_3000; m_addr_ok = 1;
    sample(); chk("post_rst_aok", d_addr_ok, 1); advance();
    d_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h1234_5678;
    sample(); chk("post_rst_dok", d_data_ok, 1); chk("post_rst_rdata", d_rdata, 32'h1234_5678);
    advance();
    m_data_ok = 0;

    // Four back-to-back tie pairs, starting fresh from reset.
    rst = 0; sample(); advance(); rst = 1;
    m_addr_ok = 1; m_data_ok = 1; n_obs = 0;
    for (int p = 0; p < 4; p++) begin
      i_req = 1; d_req = 1; i_addr = $urandom; d_addr = $urandom;
      i_got = 0; d_got = 0;
      for (int t = 0; t < 20 && !(i_got && d_got); t++) begin
        sample();
        if (i_addr_ok && n_obs < 8) begin obs[n_obs] = 1; n_obs++; end
        if (d_addr_ok && n_obs < 8) begin obs[n_obs] = 2; n_obs++; end
        if (i_addr_ok) i_got = 1;
        if (d_addr_ok) d_got = 1;
        advance();
        if (i_got) i_req = 0;
        if (d_got) d_req = 0;
      end
      chk("tie_pair_done", {31'd0, i_got && d_got}, 1);
    end
`ifdef ARB_RR_EN
    exp_gnt = '{1, 2, 1, 2, 1, 2, 1, 2};
`else
    exp_gnt = '{2, 1, 2, 1, 2, 1, 2, 1};
`endif
    chk("tie_count", n_obs, 8);
    for (int k = 0; k < 8; k++) chk($sformatf("tie_grant%0d", k), obs[k], exp_gnt[k]);
    m_addr_ok = 0; m_data_ok = 0;
    sample(); advance();

    // Randomized traffic; requesters hold req until their address is taken.
    pend_i = 0; pend_d = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 199) != 0);
      if (!pend_i && $urandom_range(0, 2) == 0) begin
        pend_i = 1; i_addr = $urandom; i_wr = 1'($urandom_range(0, 1));
        i_size = 2'($urandom_range(0, 3)); i_wdata = $urandom;
      end
      if (!pend_d && $urandom_range(0, 2) == 0) begin
        pend_d = 1; d_addr = $urandom; d_wr = 1'($urandom_range(0, 1));
        d_size = 2'($urandom_range(0, 3)); d_wdata = $urandom;
      end
      i_req = pend_i; d_req = pend_d;
      m_addr_ok = 1'($urandom_range(0, 1));
      m_data_ok = ($urandom_range(0, 2) == 0);
      m_rdata = $urandom;
      sample();
      if (e_iaok) pend_i = 0;
      if (e_daok) pend_d = 0;
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
- Shares the single sram-like memory port (toward the AXI bridge) between the instruction cache miss path and the data cache miss/uncached path.
- Grants one requester at a time and allows one outstanding transaction in total.
- Holds the grant from request until data_ok, routes addr_ok/data_ok/rdata back to the owner, and keeps the other side stalled.
- Sits between the two cache controllers and the sram-to-AXI interface in the CPU top.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all wdata/rdata buses.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- i_req  in  1  inst-side request.
- i_wr  in  1  inst-side write flag.
- i_size  in  2  inst-side size.
- i_addr  in  ADDR_WIDTH  inst-side address.
- i_wdata  in  DATA_WIDTH  inst-side write data.
- i_rdata  out  DATA_WIDTH  read data to inst side.
- i_addr_ok  out  1  inst-side address accepted.
- i_data_ok  out  1  inst-side data returned.
- d_req, d_wr, d_size, d_addr, d_wdata  in  1/1/2/ADDR_WIDTH/DATA_WIDTH  data-side request bundle.
- d_rdata  out  DATA_WIDTH  read data to data side.
- d_addr_ok, d_data_ok  out  1/1  data-side handshakes.
- m_req, m_wr, m_size, m_addr, m_wdata  out  1/1/2/ADDR_WIDTH/DATA_WIDTH  bus-side request bundle.
- m_rdata  in  DATA_WIDTH  bus-side read data.
- m_addr_ok, m_data_ok  in  1/1  bus-side handshakes.

Behaviour:
- States:
  - IDLE.
  - REQ_I, REQ_D: grant locked, waiting for m_addr_ok.
  - RSP_I, RSP_D: address accepted, waiting for m_data_ok.
- Reset:
  - While rst==0, state goes to IDLE and the last-grant register clears to "data".
  - During reset, force m_req, i_addr_ok, i_data_ok, d_addr_ok and d_data_ok to 0.
  - rdata outputs are don't-care during reset.
- IDLE:
  - Winner is chosen combinationally in the same cycle: data side wins if d_req, else inst side.
  - The winner's bundle drives m_* and m_req = winner req (zero-cycle forwarding).
  - If m_addr_ok in the same cycle: assert winner's addr_ok and go to RSP_x.
  - Else, if any req: go to REQ_x.
  - m_data_ok in IDLE is ignored and never forwarded.
- REQ_x:
  - Only the owner's bundle drives m_*; the other side's req is not forwarded.
  - The owner's addr_ok equals m_addr_ok. On m_addr_ok, go to RSP_x.
  - If the owner drops req before addr_ok (protocol violation), m_req follows it to 0 and the FSM returns to IDLE.
- RSP_x:
  - m_req = 0; no new address is issued (one outstanding transaction only).
  - On m_data_ok: assert the owner's data_ok and go to IDLE.
- Non-owner:
  - addr_ok and data_ok are held at 0 in every state.
  - A pending req simply waits; no request is ever dropped or reordered.
- Read data: m_rdata is broadcast to both i_rdata and d_rdata; validity is indicated only by the data_ok outputs.
- Bubble: a req present in the same cycle as m_data_ok is served starting the next cycle (IDLE), giving a minimum of 1 bubble between transactions.
- Write transactions use the same path; the data_ok for a write is forwarded identically.
- Bus latency: m_* is a combinational pass-through of the owner's bundle, adding no cycles beyond the bus's own latency.
- Reset mid-transaction: the FSM returns to IDLE. A stale m_data_ok arriving afterward is discarded, because the IDLE rule ignores it.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined:
  - The arbiter is round-robin.
  - A 1-bit last-grant register updates on each accepted address (m_req && m_addr_ok).
  - When both sides request in IDLE, the side not granted last wins.
  - The register resets to "data", so the first simultaneous tie goes to inst.
- Undefined: fixed priority, data side always wins ties; no last-grant register is built.

Test Plan:
- Inst-only read: i_req=1, addr 0xBFC00000; bus gives addr_ok in cycle 0 and data_ok with m_rdata=0x3C1DBFC0 two cycles later -> i_addr_ok in cycle 0, i_data_ok=1 and i_rdata=0x3C1DBFC0 in that cycle; d_* handshakes stay 0.
- Simultaneous requests: i_req and d_req both high; d_addr=0x80001000 write, wdata=0xDEADBEEF -> m_addr=0x80001000, m_wr=1. After d_data_ok, the inst request is issued the next cycle.
- Locked grant: i_req alone with m_addr_ok held 0 for 3 cycles; d_req rises in cycle 1 -> m_addr stays at the inst address until addr_ok, and d_addr_ok=0 throughout.
- Single outstanding: in RSP_I, d_req=1 and m_addr_ok=1 -> m_req=0 and d_addr_ok=0 until i_data_ok.
- Reset mid-transaction: rst=0 during RSP_D, then m_data_ok pulses after release -> d_data_ok and i_data_ok stay 0; the next request is served normally.
- ARB_RR_EN: four back-to-back simultaneous request pairs -> grants alternate I, D, I, D. Without the macro -> D, I, D, I, i.e. data is granted on every tie and inst only after each data transaction completes.
